// File: rtl/quick_rs232_pkg.sv
// Shared definitions for the quick_rs232 UART and the TX arbiter that feeds it.
package quick_rs232_pkg;

    localparam int unsigned PARITY_NONE       = 0;
    localparam int unsigned PARITY_ODD        = 1;
    localparam int unsigned PARITY_EVEN       = 2;
    localparam int unsigned STOP_BITS_ONE     = 1;
    localparam int unsigned STOP_BITS_TWO     = 2;
    localparam int unsigned FLOW_CTRL_NONE    = 0;
    localparam int unsigned FLOW_CTRL_RTS_CTS = 1;

    typedef enum logic [2:0] {
        ARB_IDLE,
        ARB_ARB,
        ARB_LOAD,
        ARB_WAIT_COPY,
        ARB_WAIT_DONE,
        ARB_RELEASE
    } arb_state_t;

    // Position of the set bit in a one-hot vector of up to 8 requesters.
    function automatic int unsigned onehot_index(input logic [7:0] vec);
        int unsigned idx;
        idx = 0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (vec[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first valid requester after the pointer, one-hot.
module rr_priority_pick #(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req_valid,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_winner
);

    logic             w_found;
    logic [PTR_W-1:0] w_idx;

    always_comb begin
        o_winner = '0;
        w_found  = 1'b0;
        w_idx    = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            w_idx = PTR_W'((32'(i_ptr) + k) % NUM_REQ);
            if (!w_found && i_req_valid[w_idx]) begin
                o_winner[w_idx] = 1'b1;
                w_found         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rs232_tx_arbiter.sv
// Round-robin packet arbiter sharing one quick_rs232 transmitter between NUM_REQ
// byte-stream requesters; a grant lasts a whole packet, closed by req_last.
module rs232_tx_arbiter
    import quick_rs232_pkg::*;
#(
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned BYTE_LEN      = 8,
    parameter int unsigned STALL_TIMEOUT = 1024
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*BYTE_LEN-1:0] req_data,
    input  logic [NUM_REQ-1:0]          req_last,
    output logic [NUM_REQ-1:0]          req_ack,
    output logic [NUM_REQ-1:0]          grant,
    output logic                        stall_error,
    output logic                        uart_tx_transaction,
    output logic [BYTE_LEN-1:0]         uart_tx_data,
    output logic                        uart_tx_data_ready,
    input  logic                        uart_tx_data_copied,
    input  logic                        uart_tx_busy
);

    localparam int unsigned PTR_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(STALL_TIMEOUT + 1);

    arb_state_t          r_state;
    logic [PTR_W-1:0]    r_ptr;
    logic [NUM_REQ-1:0]  r_grant;
    logic [NUM_REQ-1:0]  r_req_ack;
    logic                r_stall_error;
    logic                r_tx_transaction;
    logic                r_tx_data_ready;
    logic [BYTE_LEN-1:0] r_tx_data;
    logic                r_last;
    logic                r_copied_d;
    logic                r_busy_d;
    logic [CNT_W-1:0]    r_stall_cnt;

    logic [NUM_REQ-1:0]  w_winner;
    logic [BYTE_LEN-1:0] w_sel_data;
    logic                w_sel_valid;
    logic                w_sel_last;
    logic                w_copied_rise;
    logic                w_busy_fall;
    logic [CNT_W-1:0]    w_stall_next;

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .i_req_valid (req_valid),
        .i_ptr       (r_ptr),
        .o_winner    (w_winner)
    );

    // Only the owner's lane is visible to the FSM; other requesters are ignored.
    always_comb begin
        w_sel_data  = '0;
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (r_grant[i]) begin
                w_sel_data  = req_data[i*BYTE_LEN +: BYTE_LEN];
                w_sel_valid = req_valid[i];
                w_sel_last  = req_last[i];
            end
        end
    end

    assign w_copied_rise = uart_tx_data_copied & ~r_copied_d;
    assign w_busy_fall   = ~uart_tx_busy & r_busy_d;
    assign w_stall_next  = r_stall_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= ARB_IDLE;
            r_ptr            <= PTR_W'(NUM_REQ - 1);
            r_grant          <= '0;
            r_req_ack        <= '0;
            r_stall_error    <= 1'b0;
            r_tx_transaction <= 1'b0;
            r_tx_data_ready  <= 1'b0;
            r_tx_data        <= '0;
            r_last           <= 1'b0;
            r_copied_d       <= 1'b0;
            r_busy_d         <= 1'b0;
            r_stall_cnt      <= '0;
        end else begin
            r_copied_d    <= uart_tx_data_copied;
            r_busy_d      <= uart_tx_busy;
            r_req_ack     <= '0;
            r_stall_error <= 1'b0;
            case (r_state)
                ARB_IDLE: begin
                    if (|req_valid) begin
                        r_state <= ARB_ARB;
                    end
                end
                ARB_ARB: begin
                    if (|w_winner) begin
                        r_grant          <= w_winner;
                        r_ptr            <= PTR_W'(onehot_index(8'(w_winner)));
                        r_tx_transaction <= 1'b1;
                        r_stall_cnt      <= '0;
                        r_state          <= ARB_LOAD;
                    end else begin
                        r_state <= ARB_IDLE;
                    end
                end
                ARB_LOAD: begin
                    if (w_sel_valid) begin
                        r_tx_data       <= w_sel_data;
                        r_last          <= w_sel_last;
                        r_tx_data_ready <= 1'b1;
                        r_state         <= ARB_WAIT_COPY;
                    end else begin
                        r_stall_cnt <= w_stall_next;
                        if (w_stall_next == CNT_W'(STALL_TIMEOUT)) begin
                            r_stall_error <= 1'b1;
                            r_state       <= ARB_RELEASE;
                        end
                    end
                end
                ARB_WAIT_COPY: begin
                    if (w_copied_rise) begin
                        r_tx_data_ready <= 1'b0;
                        r_req_ack       <= r_grant;
                        r_state         <= ARB_WAIT_DONE;
                    end
                end
                ARB_WAIT_DONE: begin
                    if (w_busy_fall) begin
                        if (r_last) begin
                            r_state <= ARB_RELEASE;
                        end else begin
                            r_stall_cnt <= '0;
                            r_state     <= ARB_LOAD;
                        end
                    end
                end
                ARB_RELEASE: begin
                    r_grant          <= '0;
                    r_tx_transaction <= 1'b0;
                    r_state          <= ARB_IDLE;
                end
                default: begin
                    r_state <= ARB_IDLE;
                end
            endcase
        end
    end

    assign req_ack             = r_req_ack;
    assign grant               = r_grant;
    assign stall_error         = r_stall_error;
    assign uart_tx_transaction = r_tx_transaction;
    assign uart_tx_data        = r_tx_data;
    assign uart_tx_data_ready  = r_tx_data_ready;

endmodule

// File: tb/tb_rs232_tx_arbiter.sv
// Directed/randomized bench for rs232_tx_arbiter with a behavioural UART and requesters.
module tb_rs232_tx_arbiter;

    localparam int unsigned NUM_REQ       = 4;
    localparam int unsigned BYTE_LEN      = 8;
    localparam int unsigned STALL_TIMEOUT = 16;
    localparam int unsigned FRAME_CYCLES  = 6;
    localparam int unsigned PTR_W         = 2;

    typedef struct packed {
        logic [BYTE_LEN-1:0] d;
        logic                l;
    } ent_t;

    logic                        clk = 1'b0;
    logic                        rst;
    logic [NUM_REQ-1:0]          req_valid;
    logic [NUM_REQ*BYTE_LEN-1:0] req_data;
    logic [NUM_REQ-1:0]          req_last;
    logic [NUM_REQ-1:0]          req_ack;
    logic [NUM_REQ-1:0]          grant;
    logic                        stall_error;
    logic                        uart_tx_transaction;
    logic [BYTE_LEN-1:0]         uart_tx_data;
    logic                        uart_tx_data_ready;
    logic                        uart_tx_data_copied;
    logic                        uart_tx_busy;

    rs232_tx_arbiter #(
        .NUM_REQ       (NUM_REQ),
        .BYTE_LEN      (BYTE_LEN),
        .STALL_TIMEOUT (STALL_TIMEOUT)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .req_valid           (req_valid),
        .req_data            (req_data),
        .req_last            (req_last),
        .req_ack             (req_ack),
        .grant               (grant),
        .stall_error         (stall_error),
        .uart_tx_transaction (uart_tx_transaction),
        .uart_tx_data        (uart_tx_data),
        .uart_tx_data_ready  (uart_tx_data_ready),
        .uart_tx_data_copied (uart_tx_data_copied),
        .uart_tx_busy        (uart_tx_busy)
    );

    always #5 clk = ~clk;

    int                  n_checks;
    int                  n_errors;
    ent_t                rq [NUM_REQ][$];
    logic [BYTE_LEN-1:0] rx[$];
    logic [BYTE_LEN-1:0] exp_rx[$];
    logic [NUM_REQ-1:0]  glog[$];
    logic [NUM_REQ-1:0]  exp_g[$];
    int unsigned         gaps[$];
    int unsigned         acks [NUM_REQ];
    logic [NUM_REQ-1:0]  hold;
    logic [NUM_REQ-1:0]  hold_after_ack;
    int unsigned         u_cnt;
    int unsigned         n_stall;
    logic                prev_stall;
    logic                prev_grant_nz;
    int unsigned         gap_cnt;
    logic                gap_armed;
    int unsigned         m_ptr;
    logic [BYTE_LEN-1:0] pkt [NUM_REQ][2];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic int unsigned rr_next(input int unsigned ptr, input logic [NUM_REQ-1:0] pend);
        logic [PTR_W-1:0] ix;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            ix = PTR_W'((ptr + k) % NUM_REQ);
            if (pend[ix]) return 32'(ix);
        end
        return ptr;
    endfunction

    function automatic logic all_empty();
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rq[i].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic drive();
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rq[i].size() != 0 && !hold[i]) begin
                req_valid[i]                     = 1'b1;
                req_data[i*BYTE_LEN +: BYTE_LEN] = rq[i][0].d;
                req_last[i]                      = rq[i][0].l;
            end else begin
                req_valid[i]                     = 1'b0;
                req_data[i*BYTE_LEN +: BYTE_LEN] = BYTE_LEN'($urandom);
                req_last[i]                      = 1'($urandom);
            end
        end
    endtask

    task automatic clear_models();
        for (int i = 0; i < NUM_REQ; i++) begin
            rq[i].delete();
            acks[i] = 0;
        end
        hold                = '0;
        hold_after_ack      = '0;
        u_cnt               = 0;
        uart_tx_data_copied = 1'b0;
        uart_tx_busy        = 1'b0;
        rx.delete();
        exp_rx.delete();
        glog.delete();
        gaps.delete();
        gap_cnt       = 0;
        gap_armed     = 1'b0;
        prev_stall    = 1'b0;
        prev_grant_nz = 1'b0;
        n_stall       = 0;
        drive();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ack[i]) begin
                acks[i]++;
                if (rq[i].size() != 0) void'(rq[i].pop_front());
                if (hold_after_ack[i]) begin
                    hold[i]           = 1'b1;
                    hold_after_ack[i] = 1'b0;
                end
            end
        end
        if (req_ack != '0) check("ack_matches_grant", 64'(req_ack), 64'(grant));
        if (prev_stall) check("grant_clear_after_stall", 64'(grant), 64'd0);
        if (stall_error) n_stall++;
        prev_stall = stall_error;
        if (grant != '0 && !prev_grant_nz) glog.push_back(grant);
        prev_grant_nz = (grant != '0);
        if (uart_tx_transaction) begin
            if (gap_cnt != 0) gaps.push_back(gap_cnt);
            gap_cnt   = 0;
            gap_armed = 1'b1;
        end else if (gap_armed) begin
            gap_cnt++;
        end
        // UART: copy on data_ready, one-cycle copied pulse, busy for a frame time
        if (u_cnt != 0) begin
            uart_tx_data_copied = 1'b0;
            u_cnt--;
            if (u_cnt == 0) uart_tx_busy = 1'b0;
        end else if (uart_tx_data_ready && uart_tx_transaction) begin
            rx.push_back(uart_tx_data);
            uart_tx_data_copied = 1'b1;
            uart_tx_busy        = 1'b1;
            u_cnt               = FRAME_CYCLES;
        end
        drive();
    endtask

    task automatic run_idle(input string tag, input int unsigned max_cycles);
        int unsigned n;
        logic        done;
        n    = 0;
        done = 1'b0;
        while (!done && n < max_cycles) begin
            tick();
            n++;
            done = all_empty() && (grant == '0) && (u_cnt == 0);
        end
        check({tag, "_completes"}, 64'(done), 64'd1);
    endtask

    task automatic cmp_rx(input string tag);
        check({tag, "_rx_count"}, 64'(rx.size()), 64'(exp_rx.size()));
        for (int i = 0; i < exp_rx.size() && i < rx.size(); i++) begin
            check({tag, "_rx_byte"}, 64'(rx[i]), 64'(exp_rx[i]));
        end
        rx.delete();
        exp_rx.delete();
    endtask

    task automatic cmp_glog(input string tag);
        check({tag, "_grant_count"}, 64'(glog.size()), 64'(exp_g.size()));
        for (int i = 0; i < exp_g.size() && i < glog.size(); i++) begin
            check({tag, "_grant_order"}, 64'(glog[i]), 64'(exp_g[i]));
        end
        glog.delete();
        exp_g.delete();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_req_ack"}, 64'(req_ack), 64'd0);
        check({tag, "_grant"}, 64'(grant), 64'd0);
        check({tag, "_stall_error"}, 64'(stall_error), 64'd0);
        check({tag, "_tx_transaction"}, 64'(uart_tx_transaction), 64'd0);
        check({tag, "_tx_data"}, 64'(uart_tx_data), 64'd0);
        check({tag, "_tx_data_ready"}, 64'(uart_tx_data_ready), 64'd0);
    endtask

    initial begin
        logic [BYTE_LEN-1:0] x, y, z;
        logic [NUM_REQ-1:0]  pend;
        int unsigned         w;
        int unsigned         n;

        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        clear_models();
        repeat (3) tick();
        check_outputs_zero("reset");
        rst = 1'b0;
        tick();

        // Single requester 1, fixed 3-byte packet, with latency checks
        rq[1].push_back('{d: 8'h55, l: 1'b0});
        rq[1].push_back('{d: 8'hA3, l: 1'b0});
        rq[1].push_back('{d: 8'h0F, l: 1'b1});
        exp_rx = '{8'h55, 8'hA3, 8'h0F};
        drive();
        tick();
        check("t1_grant_after_1", 64'(grant), 64'd0);
        tick();
        check("t1_grant_after_2", 64'(grant), 64'h2);
        check("t1_transaction_after_2", 64'(uart_tx_transaction), 64'd1);
        check("t1_ready_after_2", 64'(uart_tx_data_ready), 64'd0);
        tick();
        check("t1_ready_after_3", 64'(uart_tx_data_ready), 64'd1);
        check("t1_first_data", 64'(uart_tx_data), 64'h55);
        run_idle("t1", 400);
        cmp_rx("t1");
        check("t1_acks", 64'(acks[1]), 64'd3);
        exp_g.push_back(4'b0010);
        cmp_glog("t1");
        check("t1_grant_idle", 64'(grant), 64'd0);

        // Fresh pointer, then all four requesters post 2-byte packets together
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_models();
        m_ptr = NUM_REQ - 1;
        for (int r = 0; r < NUM_REQ; r++) begin
            pkt[r][0] = BYTE_LEN'($urandom);
            pkt[r][1] = BYTE_LEN'($urandom);
            rq[r].push_back('{d: pkt[r][0], l: 1'b0});
            rq[r].push_back('{d: pkt[r][1], l: 1'b1});
        end
        pend = '1;
        while (pend != '0) begin
            w = rr_next(m_ptr, pend);
            exp_rx.push_back(pkt[w][0]);
            exp_rx.push_back(pkt[w][1]);
            exp_g.push_back(NUM_REQ'(1) << w);
            pend[PTR_W'(w)] = 1'b0;
            m_ptr = w;
        end
        drive();
        run_idle("t2", 2000);
        cmp_rx("t2");
        cmp_glog("t2");
        for (int r = 0; r < NUM_REQ; r++) check("t2_acks", 64'(acks[r]), 64'd2);

        // Requester 2 stalls mid-packet; pending requester 3 takes over
        clear_models();
        x = BYTE_LEN'($urandom);
        y = BYTE_LEN'($urandom);
        z = BYTE_LEN'($urandom);
        rq[2].push_back('{d: x, l: 1'b0});
        rq[2].push_back('{d: y, l: 1'b1});
        rq[3].push_back('{d: z, l: 1'b1});
        hold_after_ack[2] = 1'b1;
        drive();
        n = 0;
        while (grant != 4'b1000 && n < 500) begin
            tick();
            n++;
        end
        check("t3_req3_granted", 64'(grant), 64'h8);
        check("t3_stall_pulses", 64'(n_stall), 64'd1);
        hold[2] = 1'b0;
        drive();
        run_idle("t3", 1000);
        exp_rx = '{x, z, y};
        cmp_rx("t3");
        exp_g = '{4'b0100, 4'b1000, 4'b0100};
        cmp_glog("t3");
        check("t3_stall_total", 64'(n_stall), 64'd1);

        // Reset while the second byte of a packet is in flight
        clear_models();
        x = BYTE_LEN'($urandom);
        y = BYTE_LEN'($urandom);
        rq[1].push_back('{d: x, l: 1'b0});
        rq[1].push_back('{d: y, l: 1'b1});
        drive();
        n = 0;
        while (acks[1] < 2 && n < 500) begin
            tick();
            n++;
        end
        check("t4_second_byte_acked", 64'(acks[1]), 64'd2);
        rst = 1'b1;
        tick();
        check_outputs_zero("t4_rst");
        rst = 1'b0;
        exp_rx = '{x, y};
        cmp_rx("t4_pre");
        for (int i = 0; i < NUM_REQ; i++) rq[i].delete();
        u_cnt               = 0;
        uart_tx_data_copied = 1'b0;
        uart_tx_busy        = 1'b0;
        drive();
        repeat (3) tick();
        check("t4_no_extra_ack", 64'(acks[1]), 64'd2);
        clear_models();
        x = BYTE_LEN'($urandom);
        y = BYTE_LEN'($urandom);
        rq[0].push_back('{d: x, l: 1'b1});
        rq[3].push_back('{d: y, l: 1'b1});
        drive();
        run_idle("t4_post", 500);
        exp_rx = '{x, y};
        cmp_rx("t4_post");
        exp_g = '{4'b0001, 4'b1000};
        cmp_glog("t4_post");

        // Back-to-back single-byte packets from requester 3
        clear_models();
        for (int i = 0; i < 3; i++) begin
            x = BYTE_LEN'($urandom);
            rq[3].push_back('{d: x, l: 1'b1});
            exp_rx.push_back(x);
            exp_g.push_back(4'b1000);
        end
        drive();
        run_idle("t5", 1000);
        cmp_rx("t5");
        cmp_glog("t5");
        check("t5_acks", 64'(acks[3]), 64'd3);
        check("t5_gap_count", 64'(gaps.size()), 64'd2);
        for (int i = 0; i < gaps.size(); i++) check("t5_gap_len", 64'(gaps[i]), 64'd2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
